// File: rtl/ping_pong_buffer_if.sv
// JTAG-side and DMA-side signal bundle for the ping-pong buffer.
// slave = the buffer itself, master = the JTAG controller / DMA engine driving it.
interface ping_pong_buffer_if #(
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]           pp_address;
  logic                  pp_writeEnable;
  logic [DATA_WIDTH-1:0] pp_dataIn;
  logic [DATA_WIDTH-1:0] pp_dataOut;
  logic                  pp_switch;
  logic                  switch_ready;
  logic [AW-1:0]         dma_address;
  logic                  dma_writeEnable;
  logic [DATA_WIDTH-1:0] dma_dataIn;
  logic [DATA_WIDTH-1:0] dma_dataOut;
  logic                  dma_busy;
  logic [AW:0]           dma_word_count;
  logic                  switch_error;
  logic                  addr_error;

  modport slave (
    input  pp_address, pp_writeEnable, pp_dataIn, pp_switch,
           dma_address, dma_writeEnable, dma_dataIn, dma_busy,
    output pp_dataOut, switch_ready, dma_dataOut, dma_word_count,
           switch_error, addr_error
  );

  modport master (
    output pp_address, pp_writeEnable, pp_dataIn, pp_switch,
           dma_address, dma_writeEnable, dma_dataIn, dma_busy,
    input  pp_dataOut, switch_ready, dma_dataOut, dma_word_count,
           switch_error, addr_error
  );
endinterface

// File: rtl/ping_pong_buffer.sv
// Dual-bank word buffer: JTAG owns bank[bank_sel], DMA owns the other;
// an accepted switch swaps ownership and hands the JTAG fill count to the DMA side.
module ping_pong_buffer #(
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                JTCK,
  input  logic                JRSTN,
  ping_pong_buffer_if.slave   bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_bank0 [DEPTH];
  logic [DATA_WIDTH-1:0] r_bank1 [DEPTH];

  logic                  r_bank_sel;
  logic                  r_cooldown;
  logic [AW:0]           r_fill_count;
  logic [AW:0]           r_dma_word_count;
  logic [DATA_WIDTH-1:0] r_pp_data_out;
  logic [DATA_WIDTH-1:0] r_dma_data_out;
  logic                  r_switch_error;
  logic                  r_addr_error;

  logic [AW-1:0]         w_jtag_addr;
  logic                  w_addr_bad;
  logic                  w_jtag_we;
  logic                  w_switch_ready;
  logic                  w_swap;
  logic [AW:0]           w_addr_plus1;
  logic [AW:0]           w_fill_next;

  assign w_jtag_addr    = bus.pp_address[AW-1:0];
  assign w_addr_bad     = bus.pp_address[AW];
  assign w_jtag_we      = bus.pp_writeEnable & ~w_addr_bad;
  assign w_switch_ready = ~bus.dma_busy & ~r_cooldown;
  assign w_swap         = bus.pp_switch & w_switch_ready;
  assign w_addr_plus1   = {1'b0, w_jtag_addr} + {{AW{1'b0}}, 1'b1};

  // A write coinciding with a swap still counts toward the handed-over total.
  always_comb begin
    w_fill_next = r_fill_count;
    if (w_jtag_we && (w_addr_plus1 > r_fill_count))
      w_fill_next = w_addr_plus1;
  end

  always_ff @(posedge JTCK) begin
    if (w_jtag_we && !r_bank_sel)          r_bank0[w_jtag_addr]     <= bus.pp_dataIn;
    if (bus.dma_writeEnable && r_bank_sel) r_bank0[bus.dma_address] <= bus.dma_dataIn;
    if (w_jtag_we && r_bank_sel)           r_bank1[w_jtag_addr]     <= bus.pp_dataIn;
    if (bus.dma_writeEnable && !r_bank_sel) r_bank1[bus.dma_address] <= bus.dma_dataIn;
  end

  always_ff @(posedge JTCK or negedge JRSTN) begin
    if (!JRSTN) begin
      r_bank_sel       <= 1'b0;
      r_cooldown       <= 1'b0;
      r_fill_count     <= '0;
      r_dma_word_count <= '0;
      r_pp_data_out    <= '0;
      r_dma_data_out   <= '0;
      r_switch_error   <= 1'b0;
      r_addr_error     <= 1'b0;
    end else begin
      if (w_addr_bad)
        r_pp_data_out <= '0;
      else
        r_pp_data_out <= r_bank_sel ? r_bank1[w_jtag_addr] : r_bank0[w_jtag_addr];
      r_dma_data_out <= r_bank_sel ? r_bank0[bus.dma_address] : r_bank1[bus.dma_address];

      if (w_addr_bad) r_addr_error <= 1'b1;
      if (bus.pp_switch && !w_switch_ready) r_switch_error <= 1'b1;

      r_cooldown <= w_swap;
      if (w_swap) begin
        r_bank_sel       <= ~r_bank_sel;
        r_dma_word_count <= w_fill_next;
        r_fill_count     <= '0;
      end else begin
        r_fill_count     <= w_fill_next;
      end
    end
  end

  assign bus.pp_dataOut     = r_pp_data_out;
  assign bus.dma_dataOut    = r_dma_data_out;
  assign bus.switch_ready   = w_switch_ready;
  assign bus.dma_word_count = r_dma_word_count;
  assign bus.switch_error   = r_switch_error;
  assign bus.addr_error     = r_addr_error;
endmodule

// File: tb/tb_ping_pong_buffer.sv
// Directed plus random stimulus for ping_pong_buffer against a per-cycle
// transaction model holding both banks as plain arrays.
module tb_ping_pong_buffer;
  logic JTCK  = 1'b0;
  logic JRSTN = 1'b1;
  always #5 JTCK = ~JTCK;

  ping_pong_buffer_if #(.DEPTH(256), .DATA_WIDTH(32)) bus ();

  ping_pong_buffer #(.DEPTH(256), .DATA_WIDTH(32)) dut (
    .JTCK  (JTCK),
    .JRSTN (JRSTN),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] m_mem   [2][256];
  bit          m_known [2][256];
  int          m_bs, m_fill, m_wc;
  bit          m_cool, m_serr, m_aerr;
  logic [31:0] e_pp, e_dma;
  bit          e_pp_k, e_dma_k;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bs = 0; m_fill = 0; m_wc = 0;
    m_cool = 0; m_serr = 0; m_aerr = 0;
    e_pp = '0; e_dma = '0; e_pp_k = 1; e_dma_k = 1;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 256; i++) m_known[b][i] = 0;
  endtask

  task automatic drive_idle();
    bus.pp_address = '0; bus.pp_writeEnable = 0; bus.pp_dataIn = '0;
    bus.pp_switch = 0; bus.dma_address = '0; bus.dma_writeEnable = 0;
    bus.dma_dataIn = '0; bus.dma_busy = 0;
  endtask

  task automatic do_reset();
    drive_idle();
    JRSTN = 1'b0;
    #2;
    chk("rst_pp_dataOut",   bus.pp_dataOut, 32'h0);
    chk("rst_dma_dataOut",  bus.dma_dataOut, 32'h0);
    chk("rst_word_count",   32'(bus.dma_word_count), 32'd0);
    chk("rst_switch_error", 32'(bus.switch_error), 32'd0);
    chk("rst_addr_error",   32'(bus.addr_error), 32'd0);
    chk("rst_switch_ready", 32'(bus.switch_ready), 32'd1);
    @(posedge JTCK);
    #1;
    JRSTN = 1'b1;
    model_reset();
  endtask

  task automatic step(input logic [8:0] pa, input bit pwe, input logic [31:0] pd,
                      input bit psw, input logic [7:0] da, input bit dwe,
                      input logic [31:0] dd, input bit busy);
    int a, b;
    bit bad, ready;
    bus.pp_address = pa; bus.pp_writeEnable = pwe; bus.pp_dataIn = pd;
    bus.pp_switch = psw; bus.dma_address = da; bus.dma_writeEnable = dwe;
    bus.dma_dataIn = dd; bus.dma_busy = busy;
    @(posedge JTCK);
    a = int'(pa[7:0]); bad = pa[8]; b = m_bs;
    e_pp_k  = bad || m_known[b][a];
    e_pp    = bad ? 32'h0 : m_mem[b][a];
    e_dma_k = m_known[1-b][da];
    e_dma   = m_mem[1-b][da];
    ready   = !busy && !m_cool;
    if (pwe && !bad) begin
      m_mem[b][a] = pd; m_known[b][a] = 1;
      if (a + 1 > m_fill) m_fill = a + 1;
    end
    if (dwe) begin m_mem[1-b][da] = dd; m_known[1-b][da] = 1; end
    if (bad) m_aerr = 1;
    if (psw && !ready) m_serr = 1;
    if (psw && ready) begin
      m_wc = m_fill; m_fill = 0; m_bs = 1 - m_bs; m_cool = 1;
    end else m_cool = 0;
    #1;
    if (e_pp_k)  chk("pp_dataOut", bus.pp_dataOut, e_pp);
    if (e_dma_k) chk("dma_dataOut", bus.dma_dataOut, e_dma);
    chk("switch_ready",   32'(bus.switch_ready), 32'(!busy && !m_cool));
    chk("dma_word_count", 32'(bus.dma_word_count), 32'(m_wc));
    chk("switch_error",   32'(bus.switch_error), 32'(m_serr));
    chk("addr_error",     32'(bus.addr_error), 32'(m_aerr));
  endtask

  task automatic idle();
    step(9'd0, 0, 32'h0, 0, 8'd0, 0, 32'h0, 0);
  endtask

  initial begin
    drive_idle();
    #1;
    do_reset();
    idle();

    // Fill four words, swap, read them back on the DMA side.
    for (int i = 0; i < 4; i++) step(9'(i), 1, 32'hA000_0000 + i, 0, 8'd0, 0, 32'h0, 0);
    step(9'd0, 0, 32'h0, 1, 8'd0, 0, 32'h0, 0);
    chk("wc_after_4", 32'(bus.dma_word_count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      step(9'd0, 0, 32'h0, 0, 8'(i), 0, 32'h0, 0);
      chk("dma_read_fill", bus.dma_dataOut, 32'hA000_0000 + i);
    end

    // Fill count restarts after a swap; then address 255 must give 256.
    step(9'd1, 1, 32'h0000_0022, 0, 8'd0, 0, 32'h0, 0);
    step(9'd0, 0, 32'h0, 1, 8'd0, 0, 32'h0, 0);
    chk("wc_restart", 32'(bus.dma_word_count), 32'd2);
    idle();
    step(9'd255, 1, 32'h0000_0011, 0, 8'd0, 0, 32'h0, 0);
    step(9'd0, 0, 32'h0, 1, 8'd0, 0, 32'h0, 0);
    chk("wc_256", 32'(bus.dma_word_count), 32'd256);
    idle();

    // Swap blocked by dma_busy, then accepted once busy drops.
    step(9'd0, 0, 32'h0, 1, 8'd255, 0, 32'h0, 1);
    chk("busy_switch_error", 32'(bus.switch_error), 32'd1);
    chk("busy_wc_kept", 32'(bus.dma_word_count), 32'd256);
    step(9'd0, 0, 32'h0, 1, 8'd0, 0, 32'h0, 0);
    chk("unbusy_wc", 32'(bus.dma_word_count), 32'd0);
    idle();

    // Back-to-back switch: only the first is accepted.
    do_reset();
    step(9'd0, 1, 32'h0000_1234, 0, 8'd0, 0, 32'h0, 0);
    step(9'd0, 0, 32'h0, 1, 8'd0, 0, 32'h0, 0);
    chk("b2b_first_ok", 32'(bus.switch_error), 32'd0);
    step(9'd0, 0, 32'h0, 1, 8'd0, 0, 32'h0, 0);
    chk("b2b_second_err", 32'(bus.switch_error), 32'd1);
    step(9'd0, 0, 32'h0, 0, 8'd0, 0, 32'h0, 0);
    chk("b2b_toggled_once", bus.dma_dataOut, 32'h0000_1234);

    // Write and swap on the same cycle.
    step(9'd0, 0, 32'h0, 0, 8'd7, 1, 32'h5555_AAAA, 0);
    idle();
    step(9'd7, 1, 32'hDEAD_BEEF, 1, 8'd0, 0, 32'h0, 0);
    chk("same_cycle_wc", 32'(bus.dma_word_count), 32'd8);
    step(9'd7, 0, 32'h0, 0, 8'd7, 0, 32'h0, 0);
    chk("same_cycle_dma", bus.dma_dataOut, 32'hDEAD_BEEF);
    chk("same_cycle_jtag", bus.pp_dataOut, 32'h5555_AAAA);

    // Out-of-range JTAG address.
    step(9'h100, 1, 32'h0BAD_0BAD, 0, 8'd0, 0, 32'h0, 0);
    chk("bad_addr_err", 32'(bus.addr_error), 32'd1);
    chk("bad_addr_data", bus.pp_dataOut, 32'h0);
    step(9'd0, 0, 32'h0, 0, 8'd0, 0, 32'h0, 0);
    chk("bad_addr_nowrite", bus.pp_dataOut, 32'h0000_1234);
    do_reset();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [8:0] pa;
      pa = 9'($urandom_range(0, 255));
      if ($urandom_range(0, 31) == 0) pa[8] = 1'b1;
      step(pa, $urandom_range(0, 1) == 1, $urandom,
           $urandom_range(0, 7) == 0, 8'($urandom_range(0, 255)),
           $urandom_range(0, 9) < 3, $urandom, $urandom_range(0, 3) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ping_pong_buffer.md
# ping_pong_buffer

Dual-bank 32-bit word buffer between the JTAG chain-1 controller and the DMA engine. One bank is always owned by the JTAG side (filled with write data or drained of read data); the other is owned by the DMA side. A single-cycle switch pulse swaps ownership, and the word count written by the JTAG side is handed over with the bank. Both sides run in the JTAG clock domain.

## Interface

Parameters:
- DEPTH, 256, words per bank; address width is log2(DEPTH).
- DATA_WIDTH, 32, word width.

Ports:
- JTCK  in  1  clock; all logic on rising edge.
- JRSTN  in  1  reset, asynchronous, active-low.
- pp_address  in  9  JTAG-side word address; bit 8 must be 0.
- pp_writeEnable  in  1  JTAG-side write strobe.
- pp_dataIn  in  32  JTAG-side write data.
- pp_dataOut  out  32  JTAG-side registered read data.
- pp_switch  in  1  bank swap request, single-cycle pulse.
- switch_ready  out  1  swap will be accepted this cycle.
- dma_address  in  8  DMA-side word address.
- dma_writeEnable  in  1  DMA-side write strobe (read-from-memory fill).
- dma_dataIn  in  32  DMA-side write data.
- dma_dataOut  out  32  DMA-side registered read data.
- dma_busy  in  1  DMA transfer in progress; blocks swaps.
- dma_word_count  out  9  words handed over with the DMA bank (0..256).
- switch_error  out  1  sticky: pp_switch seen while switch_ready low.
- addr_error  out  1  sticky: JTAG access with pp_address[8]=1.

## Operation

- bank_sel register: JTAG side accesses bank[bank_sel], DMA side accesses bank[~bank_sel]. The two sides never share a bank.
- Memories: 2 x DEPTH x 32, not reset. Each port: synchronous write, synchronous read-first (a read and write to the same address on the same cycle return old data).
- JTAG write with pp_address[8]=0: bank[bank_sel][pp_address[7:0]] <= pp_dataIn. fill_count <= max(fill_count, pp_address[7:0]+1), 9-bit arithmetic, so address 255 gives 256.
- pp_address[8]=1: the write is dropped, pp_dataOut <= 0 on the next edge, and addr_error is set.
- Swap accepted when pp_switch=1 and switch_ready=1:
  - bank_sel toggles.
  - dma_word_count <= fill_count.
  - fill_count <= 0.
- switch_ready = ~dma_busy & ~cooldown. cooldown is a register set for exactly one cycle after an accepted swap.
- Rejected swap (pp_switch=1, switch_ready=0): no state change except switch_error <= 1.
- switch_error and addr_error clear only on reset.
- Write and swap on the same cycle: the write lands in the old JTAG bank and counts toward the handed-over fill_count.

## Timing

- Reset values: bank_sel=0, fill_count=0, dma_word_count=0, cooldown=0, pp_dataOut=0, dma_dataOut=0, switch_error=0, addr_error=0.
  - switch_ready is therefore 1 after reset if dma_busy=0.
  - Reset asserted mid-operation clears all of these immediately. Memory contents are retained but are undefined from the spec's point of view.
- Read latency: 1 cycle on both ports. An address presented before edge N gives data valid after edge N.
- Swap sampled at edge N:
  - Accesses sampled at edge N use the old bank_sel.
  - Accesses from edge N+1 use the new banks.
  - switch_ready is low for the cycle after N, and high again after edge N+1 if dma_busy=0.
  - dma_word_count is valid after edge N.
- Back-to-back pp_switch on N and N+1: the second is rejected and sets switch_error.

## Test plan

- Reset, then JTAG writes 0xA0000000+i to addresses 0..3, then swap -> dma_word_count=4. DMA reads of addresses 0..3 return 0xA0000000..0xA0000003 one cycle after each address. The JTAG-side fill count restarts at 0.
- Write 0x11 at address 255, then swap -> dma_word_count=256 (no 8-bit wrap).
- dma_busy=1, then pp_switch pulse -> switch_ready=0, bank_sel unchanged, switch_error=1. Drop dma_busy and pulse again -> swap accepted.
- pp_switch on two consecutive cycles -> the first is accepted, the second is rejected, switch_error=1. bank_sel toggles exactly once.
- Write 0xDEADBEEF and swap on the same cycle at address 7 -> after the swap, DMA read of address 7 = 0xDEADBEEF and dma_word_count=8. JTAG read of address 7 returns the new bank's content.
- pp_address=0x100 with write -> no memory change, addr_error=1, pp_dataOut=0. Then assert JRSTN low mid-stream -> all outputs take their reset values immediately, without waiting for JTCK.
